// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator feeder: FSM states, default sizes and
// the handshake level used on Load and Done_In by both ends of the link.
package acc_pkg;

    localparam int DW_DEF      = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 64;

    // Level that marks an active Load / Done_In strobe
    localparam logic HS_ON = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/acc_feeder_if.sv
// Host and accumulator-side signal bundle of acc_feeder; slave is the feeder,
// master is whatever drives the host writes and models the accumulator.
interface acc_feeder_if
    import acc_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic          Wr_En;
    logic [DW-1:0] Wr_Data;
    logic          Full;
    logic [LW-1:0] Level;
    logic          Start;
    logic          Busy;
    logic          Load;
    logic [DW-1:0] Data_Out;
    logic          Done_In;
    logic [DW-1:0] Acc_In;
    logic [DW-1:0] Result;
    logic          Result_Valid;
    logic          Error;

    modport slave (
        input  Wr_En, Wr_Data, Start, Done_In, Acc_In,
        output Full, Level, Busy, Load, Data_Out, Result, Result_Valid, Error
    );

    modport master (
        output Wr_En, Wr_Data, Start, Done_In, Acc_In,
        input  Full, Level, Busy, Load, Data_Out, Result, Result_Valid, Error
    );

endinterface

// File: rtl/acc_feed_fifo.sv
// First-word-fall-through operand buffer: head always shows the oldest entry,
// a push while full is dropped and a pop while empty is ignored.
module acc_feed_fifo
    import acc_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    // Storage is never reset; only pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/acc_feeder.sv
// Streams buffered operand bytes to the accumulator as one Load burst per
// Start, then waits (bounded) for Done_In and captures the returned sum.
module acc_feeder
    import acc_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    acc_feeder_if.slave bus
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [LW-1:0] remaining;
    logic [CW-1:0] wait_cnt;

    logic          fifo_pop;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;
    logic          start_ok;

    assign start_ok = bus.Start && (state == IDLE) && !fifo_empty;
    // The first byte is popped on the accepting edge so Load and Data_Out rise together.
    assign fifo_pop = start_ok || ((state == SEND) && (remaining != '0));

    acc_feed_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset),
        .push      (bus.Wr_En),
        .push_data (bus.Wr_Data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (bus.Full),
        .empty     (fifo_empty),
        .level     (bus.Level)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state            <= IDLE;
            remaining        <= '0;
            wait_cnt         <= '0;
            bus.Busy         <= 1'b0;
            bus.Load         <= 1'b0;
            bus.Data_Out     <= '0;
            bus.Result       <= '0;
            bus.Result_Valid <= 1'b0;
            bus.Error        <= 1'b0;
        end else begin
            bus.Result_Valid <= 1'b0;
            bus.Error        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state        <= SEND;
                        bus.Busy     <= 1'b1;
                        bus.Load     <= HS_ON;
                        bus.Data_Out <= fifo_head;
                        remaining    <= bus.Level - LW'(1);
                    end
                end
                SEND: begin
                    // remaining counts bytes of the snapshot still to present.
                    if (remaining != '0) begin
                        bus.Data_Out <= fifo_head;
                        remaining    <= remaining - LW'(1);
                    end else begin
                        state        <= WAIT;
                        bus.Load     <= ~HS_ON;
                        bus.Data_Out <= '0;
                        wait_cnt     <= '0;
                    end
                end
                WAIT: begin
                    // Done_In wins over an expiring counter in the same cycle.
                    if (bus.Done_In == HS_ON) begin
                        state            <= IDLE;
                        bus.Busy         <= 1'b0;
                        bus.Result       <= bus.Acc_In;
                        bus.Result_Valid <= 1'b1;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        bus.Busy  <= 1'b0;
                        bus.Error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.Busy     <= 1'b0;
                    bus.Load     <= 1'b0;
                    bus.Data_Out <= '0;
                end
            endcase
        end
    end

endmodule
